sha_result_collector: RTL and testbench
=======================================

Name: sha_result_collector

Overview:
- Consumer end of the double-hash core output stream (valid, newblock, doublehash, difficulty).
- Reconstructs the nonce of each valid result from processor index/stride and compares the hash against the 32-bit difficulty target.
- Queues winning nonces in a small FIFO, read out by the host/UART side over a valid/ready handshake.
- Flushes stale results when a new block starts.

Parameters:
- PROCESSORINDEX, 0, first nonce this core handles.
- NUMPROCESSORS, 1, nonce stride between consecutive results.
- FIFO_DEPTH, 4, number of hit entries buffered (power of two, ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- valid_i  input  1  core output_valid.
- newblock_i  input  1  core newblock_o; qualified by valid_i.
- doublehash_i  input  HashState  core doublehash.
- difficulty_i  input  32  target; sampled with each valid_i.
- result_valid  output  1  FIFO non-empty.
- result_ready  input  1  consumer accepts head entry.
- result_nonce  output  32  nonce of head entry.
- result_hash_msw  output  32  byte-swapped hash word 7 of head entry.
- hit_count  output  32  hits since last newblock (saturating).
- drop_count  output  16  hits lost to a full FIFO since reset (saturating).
- nonce_exhausted  output  1  sticky: nonce space for the current block wrapped.

Behaviour:
- Reset (rst low, async): FIFO empty, result_valid=0, result_nonce=0, result_hash_msw=0, hit_count=0, drop_count=0, nonce_exhausted=0, nonce counter=PROCESSORINDEX.
- msw = byteswap(doublehash_i word 7), i.e. the most significant 32 bits of the little-endian 256-bit hash. hit = valid_i && (msw < difficulty_i), unsigned compare.
- Nonce assignment on each valid_i:
  - With newblock_i: this result's nonce = PROCESSORINDEX; counter ← PROCESSORINDEX+NUMPROCESSORS.
  - Otherwise: nonce = counter; counter ← counter+NUMPROCESSORS, mod 2^32.
  - If the 32-bit add carries out, set nonce_exhausted.
  - nonce_exhausted clears only on a valid newblock.
  - Cycles with valid_i=0 do not advance the counter.
- Latency: a hit sampled at edge N is in the FIFO after edge N; result_valid is high in cycle N+1 if the FIFO was empty.
- FIFO:
  - Pop when result_valid && result_ready. Head outputs are registered and show the FIFO head.
  - Push when hit. If the FIFO is full and no pop occurs the same cycle, drop the hit and increment drop_count (saturating at 0xFFFF).
  - Full + pop + push in the same cycle: the push is accepted and occupancy is unchanged.
- Valid newblock:
  - Flush all existing entries, including one being popped that cycle; that pop is still counted as consumed.
  - Then push the new result if it is a hit, so after the edge the FIFO holds at most the new hit.
  - hit_count ← hit ? 1 : 0.
- hit_count increments on every hit, including dropped ones, and saturates at 0xFFFFFFFF.
- newblock_i with valid_i=0 is ignored.
- Reset asserted mid-stream: immediate return to reset values. The first valid after reset without newblock uses nonce PROCESSORINDEX.
- The consumer may hold result_ready high continuously. Outputs are stable while result_valid && !result_ready.

Decomposition:
- Shared sha package:
  - typedef ResultEntry {nonce[31:0], hash_msw[31:0]}.
  - function byteswap32.
  - HashState word-index constant for word 7.
- One sub-module: sha_result_fifo, a parameterised synchronous FIFO of ResultEntry with push, pop, flush, full and empty, using the same clk/rst (async active-low).

Test Plan:
- PROCESSORINDEX=1, NUMPROCESSORS=4, difficulty_i=0x00001000:
  - Valid+newblock with msw=0x00000FFF → entry nonce=1, hash_msw=0x00000FFF, result_valid high 1 cycle later, hit_count=1.
  - Next two valids (msw=0xFFFFFFFF, then 0x00000000) → only the second is queued, nonce=9; hit_count=2.
- FIFO_DEPTH=4, result_ready=0, six consecutive hits → 4 entries with nonces 0,1,2,3 (PROCESSORINDEX=0, NUMPROCESSORS=1); drop_count=2; hit_count=6.
- Full FIFO, result_ready=1, hit in the same cycle → occupancy stays 4, head advances, drop_count unchanged.
- 3 queued entries, then valid+newblock hit with result_ready=1 → FIFO holds exactly one entry nonce=PROCESSORINDEX; hit_count=1.
- Force counter to 0xFFFFFFFE, NUMPROCESSORS=4, one valid → nonce 0xFFFFFFFE reported if hit, counter=0x00000002, nonce_exhausted=1; next valid+newblock clears it.
- Drop rst mid-burst with entries queued → result_valid=0, all counters 0 asynchronously (no clock edge needed); a valid without newblock after release gets nonce=PROCESSORINDEX.

Source files
------------

// File: rtl/sha_result_collector_pkg.sv
// rtl/sha_result_collector_pkg.sv - shared types and helpers for the double-hash result collector
//
// Purpose: hash state layout, the queued result entry, and the byte swap used to
// turn a little-endian hash word into a comparable big-endian value.
package sha_result_collector_pkg;

  localparam int HASH_WORDS    = 8;
  // Word holding the most significant 32 bits of the little-endian 256-bit hash.
  localparam int HASH_MSW_WORD = 7;

  typedef logic [HASH_WORDS-1:0][31:0] hash_state_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] hash_msw;
  } result_entry_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha_result_fifo.sv
// rtl/sha_result_fifo.sv - synchronous FIFO of result entries with flush
//
// Purpose: buffers winning results between the hash core and the host side.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, data_in write request and entry
//   pop           remove head (ignored when empty)
//   flush         discard every entry; a push in the same cycle becomes the sole entry
//   head          entry at the head of the queue, read straight from storage registers
//   full, empty   occupancy flags
module sha_result_fifo
  import sha_result_collector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  result_entry_t data_in,
  input  logic          pop,
  input  logic          flush,
  output result_entry_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_entry_t       mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         count;
  logic                do_pop;
  logic                do_push;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being read.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Restart at the current read pointer so the new entry is visible as the
      // head immediately after this edge.
      if (push) begin
        mem[rd_ptr] <= data_in;
        wr_ptr      <= rd_ptr + AW'(1);
        count       <= (AW+1)'(1);
      end else begin
        wr_ptr <= rd_ptr;
        count  <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sha_result_collector.sv
// rtl/sha_result_collector.sv - collects winning nonces from the double-hash core output
//
// Purpose: rebuilds each result's nonce from the processor index/stride, compares
// the hash against the difficulty target and queues hits for the host side.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   valid_i, newblock_i            core result strobe; newblock qualified by valid_i
//   doublehash_i, difficulty_i     core hash and target sampled with valid_i
//   result_valid/ready             head-of-queue handshake to the consumer
//   result_nonce, result_hash_msw  head entry
//   hit_count                      hits since last new block (saturating)
//   drop_count                     hits lost to a full queue since reset (saturating)
//   nonce_exhausted                sticky: nonce counter wrapped in this block
module sha_result_collector
  import sha_result_collector_pkg::*;
#(
  parameter logic [31:0] PROCESSORINDEX = 32'd0,
  parameter logic [31:0] NUMPROCESSORS  = 32'd1,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        newblock_i,
  input  hash_state_t doublehash_i,
  input  logic [31:0] difficulty_i,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_nonce,
  output logic [31:0] result_hash_msw,
  output logic [31:0] hit_count,
  output logic [15:0] drop_count,
  output logic        nonce_exhausted
);

  logic [31:0]   nonce_ctr;
  logic [31:0]   msw;
  logic          hit;
  logic          block_start;
  logic [31:0]   cur_nonce;
  logic [31:0]   next_ctr;
  logic          ctr_carry;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  result_entry_t push_entry;
  result_entry_t head;

  // Only the top word takes part in the target compare.
  logic unused_hash_words;
  assign unused_hash_words = ^doublehash_i[HASH_MSW_WORD-1:0];

  assign msw         = byteswap32(doublehash_i[HASH_MSW_WORD]);
  assign hit         = valid_i && (msw < difficulty_i);
  assign block_start = valid_i && newblock_i;

  // A new block restarts numbering at this core's first nonce; otherwise the
  // result belongs to the nonce the counter is holding.
  assign cur_nonce             = block_start ? PROCESSORINDEX : nonce_ctr;
  assign {ctr_carry, next_ctr} = {1'b0, cur_nonce} + {1'b0, NUMPROCESSORS};

  assign result_valid    = !fifo_empty;
  assign pop             = result_valid && result_ready;
  assign result_nonce    = head.nonce;
  assign result_hash_msw = head.hash_msw;

  // A hit at a new block always lands (the queue is flushed first), so only
  // in-block hits against a full, unread queue are lost.
  assign drop = hit && !block_start && fifo_full && !pop;

  assign push_entry.nonce    = cur_nonce;
  assign push_entry.hash_msw = msw;

  sha_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (hit),
    .data_in (push_entry),
    .pop     (pop),
    .flush   (block_start),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nonce_ctr       <= PROCESSORINDEX;
      nonce_exhausted <= 1'b0;
    end else if (valid_i) begin
      nonce_ctr <= next_ctr;
      // The block restart owns its first step, so a new block always starts
      // with the flag clear.
      if (block_start) begin
        nonce_exhausted <= 1'b0;
      end else if (ctr_carry) begin
        nonce_exhausted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count <= '0;
    end else if (block_start) begin
      hit_count <= hit ? 32'd1 : 32'd0;
    end else if (hit && (hit_count != '1)) begin
      hit_count <= hit_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sha_result_collector.sv
// tb/tb_sha_result_collector.sv - scoreboard bench for sha_result_collector
module tb_sha_result_collector;
  import sha_result_collector_pkg::*;

  localparam logic [31:0] PI    = 32'd1;
  localparam logic [31:0] NP    = 32'd4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] DIFF  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, newblock, result_ready;
  hash_state_t dh;
  logic [31:0] difficulty;
  logic        r_valid;
  logic [31:0] r_nonce, r_msw, hit_count;
  logic [15:0] drop_count;
  logic        exh;

  logic        x_valid, x_newblock, x_ready;
  hash_state_t x_dh;
  logic        xr_valid;
  logic [31:0] xr_nonce, xr_msw, x_hits;
  logic [15:0] x_drops;
  logic        x_exh;

  int checks = 0;
  int errors = 0;

  result_entry_t q[$];
  result_entry_t ent;
  logic [31:0]   m_ctr;
  logic [31:0]   exp_hits;
  logic [15:0]   exp_drops;

  sha_result_collector #(.PROCESSORINDEX(PI), .NUMPROCESSORS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .newblock_i(newblock), .doublehash_i(dh),
    .difficulty_i(difficulty), .result_valid(r_valid), .result_ready(result_ready),
    .result_nonce(r_nonce), .result_hash_msw(r_msw), .hit_count(hit_count),
    .drop_count(drop_count), .nonce_exhausted(exh));

  sha_result_collector #(.PROCESSORINDEX(32'hFFFF_FFFE), .NUMPROCESSORS(32'd4), .FIFO_DEPTH(DEPTH)) dut_x (
    .clk(clk), .rst(rst), .valid_i(x_valid), .newblock_i(x_newblock), .doublehash_i(x_dh),
    .difficulty_i(difficulty), .result_valid(xr_valid), .result_ready(x_ready),
    .result_nonce(xr_nonce), .result_hash_msw(xr_msw), .hit_count(x_hits),
    .drop_count(x_drops), .nonce_exhausted(x_exh));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: runs on the falling edge, consumes one expected entry whenever the
  // DUT presents a head that the consumer is accepting.
  always @(negedge clk) begin
    if (rst) begin
      check("valid_vs_model", {31'd0, r_valid}, {31'd0, (q.size() != 0)});
      check("hit_count", hit_count, exp_hits);
      check("drop_count", {16'd0, drop_count}, {16'd0, exp_drops});
      if (r_valid && result_ready && q.size() > 0) begin
        ent = q.pop_front();
        check("head_nonce", r_nonce, ent.nonce);
        check("head_msw", r_msw, ent.hash_msw);
      end
    end
  end

  // Drives one cycle of stimulus (called at posedge+1), updates the model at the
  // sampling edge, then returns the inputs to idle.
  task automatic issue(input logic v, input logic nb, input logic [31:0] msw, input logic rdy);
    logic [31:0] nonce;
    valid = v; newblock = nb; result_ready = rdy;
    dh[HASH_MSW_WORD] = byteswap32(msw);
    @(posedge clk);
    if (v) begin
      if (nb) begin
        nonce = PI;
        q.delete();
        exp_hits = 32'd0;
      end else begin
        nonce = m_ctr;
      end
      m_ctr = nonce + NP;
      if (msw < DIFF) begin
        if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
        if (q.size() < DEPTH) q.push_back('{nonce: nonce, hash_msw: msw});
        else if (exp_drops != 16'hFFFF) exp_drops++;
      end
    end
    #1;
    valid = 1'b0; newblock = 1'b0; result_ready = 1'b0;
  endtask

  task automatic x_issue(input logic v, input logic nb, input logic [31:0] msw, input logic rdy);
    x_valid = v; x_newblock = nb; x_ready = rdy;
    x_dh[HASH_MSW_WORD] = byteswap32(msw);
    @(posedge clk);
    #1;
    x_valid = 1'b0; x_newblock = 1'b0; x_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && q.size() != 0; i++) issue(1'b0, 1'b0, 32'd0, 1'b1);
    check("drain_bound", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid = 1'b0; newblock = 1'b0; result_ready = 1'b0;
    x_valid = 1'b0; x_newblock = 1'b0; x_ready = 1'b0;
    difficulty = DIFF;
    for (int i = 0; i < HASH_WORDS; i++) begin
      dh[i]   = 32'hA5A5_0000 + i;
      x_dh[i] = 32'h5A5A_0000 + i;
    end
    m_ctr = PI; exp_hits = 32'd0; exp_drops = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, r_valid}, 32'd0);
    check("rst_nonce", r_nonce, 32'd0);
    check("rst_msw", r_msw, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_drops", {16'd0, drop_count}, 32'd0);
    check("rst_exh", {31'd0, exh}, 32'd0);
    rst = 1'b1;

    // First hit of a block and its one-cycle latency.
    issue(1'b1, 1'b1, 32'h0000_0FFF, 1'b0);
    check("first_valid", {31'd0, r_valid}, 32'd1);
    check("first_nonce", r_nonce, 32'd1);
    check("first_msw", r_msw, 32'h0000_0FFF);
    check("first_hits", hit_count, 32'd1);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0000, 1'b0);
    check("second_hits", hit_count, 32'd2);
    drain();

    // Overfill: six hits into four slots, nonces 1,5,9,13 kept.
    issue(1'b1, 1'b1, 32'h10, 1'b0);
    for (int i = 1; i < 6; i++) issue(1'b1, 1'b0, 32'h10 + i, 1'b0);
    check("full_drops", {16'd0, drop_count}, 32'd2);
    check("full_hits", hit_count, 32'd6);
    check("full_head", r_nonce, 32'd1);

    // Full + pop + push: accepted, no drop, head advances.
    issue(1'b1, 1'b0, 32'h20, 1'b1);
    check("fpp_drops", {16'd0, drop_count}, 32'd2);
    check("fpp_head", r_nonce, 32'd5);

    // Three queued, then newblock hit while popping.
    issue(1'b0, 1'b0, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 32'h30, 1'b1);
    check("nb_head", r_nonce, 32'd1);
    check("nb_msw", r_msw, 32'h30);
    check("nb_hits", hit_count, 32'd1);
    issue(1'b0, 1'b0, 32'd0, 1'b1);
    check("nb_single", {31'd0, r_valid}, 32'd0);

    // newblock without valid is ignored.
    issue(1'b1, 1'b0, 32'h40, 1'b0);
    issue(1'b0, 1'b1, 32'h0, 1'b0);
    check("nb_novalid_head", r_nonce, 32'd5);
    check("nb_novalid_hits", hit_count, 32'd2);

    // Non-hit newblock flushes everything; msw == target is not a hit.
    issue(1'b1, 1'b1, 32'h2000, 1'b0);
    check("nb_miss_valid", {31'd0, r_valid}, 32'd0);
    issue(1'b1, 1'b0, DIFF, 1'b0);
    check("eq_target_valid", {31'd0, r_valid}, 32'd0);
    issue(1'b1, 1'b0, 32'h0FFF, 1'b0);
    check("below_target_nonce", r_nonce, 32'd9);
    issue(1'b1, 1'b0, 32'h1, 1'b0);

    // Exhaustion on the wrap-prone instance, left set across the reset below.
    x_issue(1'b1, 1'b0, 32'h0, 1'b0);
    check("x_nonce0", xr_nonce, 32'hFFFF_FFFE);
    check("x_exh_set", {31'd0, x_exh}, 32'd1);
    x_issue(1'b1, 1'b0, 32'h0, 1'b1);
    check("x_nonce1", xr_nonce, 32'h0000_0002);
    check("x_hits", x_hits, 32'd2);

    // Asynchronous reset mid-burst with entries queued.
    rst = 1'b0;
    q.delete(); exp_hits = 32'd0; exp_drops = 16'd0; m_ctr = PI;
    #2;
    check("arst_valid", {31'd0, r_valid}, 32'd0);
    check("arst_nonce", r_nonce, 32'd0);
    check("arst_hits", hit_count, 32'd0);
    check("arst_drops", {16'd0, drop_count}, 32'd0);
    check("arst_x_exh", {31'd0, x_exh}, 32'd0);
    check("arst_x_valid", {31'd0, xr_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue(1'b1, 1'b0, 32'h7, 1'b0);
    check("post_rst_nonce", r_nonce, 32'd1);
    drain();

    // Wrap again after reset, then a new block clears the flag.
    x_issue(1'b1, 1'b0, 32'h0, 1'b0);
    check("x_post_rst_nonce", xr_nonce, 32'hFFFF_FFFE);
    check("x_exh_reset", {31'd0, x_exh}, 32'd1);
    x_issue(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("x_exh_clear", {31'd0, x_exh}, 32'd0);
    check("x_nb_flush", {31'd0, xr_valid}, 32'd0);
    check("x_nb_hits", x_hits, 32'd0);

    issue(1'b0, 1'b0, 32'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
